mult_matrix_sequencer: RTL and testbench

// - Sequences one matrix multiply: streams the rows of operand A from a synchronous row RAM into the

---
 rtl/mult_matrix_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mult_matrix_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_matrix_sequencer.sv
// mult_matrix_sequencer: runs one matrix-multiply job. Streams the rows of
// operand A from a synchronous row RAM into the prep skew buffer, lets zero
// rows flush the systolic array, flags the cycles carrying finished result
// rows, and offers the host a start/busy/done handshake.
// Optional feature: define MULT_SEQ_PERF_EN to add the perf_cycles counter.
module mult_matrix_sequencer #(
    parameter int data_size  = 4,
    parameter int size       = 3,
    parameter int max_rows   = 16,
    parameter int result_lat = 5,
    localparam int AW = $clog2(max_rows)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [AW:0]               num_rows,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [AW-1:0]             rd_addr,
    input  logic [data_size*size-1:0] rd_data,
    output logic [data_size*size-1:0] prep_stream,
    output logic                      prep_valid,
`ifdef MULT_SEQ_PERF_EN
    output logic [31:0]               perf_cycles,
`endif
    output logic                      result_valid
);

    localparam int DW = $clog2(result_lat + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t                state;
    logic [AW:0]           row_cnt;
    logic [AW:0]           job_rows;
    logic [DW-1:0]         drain_cnt;
    logic [AW:0]           clamped_rows;
    logic                  accept;
    logic                  rd_vld;
    logic [result_lat-1:0] valid_sr;

    // Row count the job will use, clamped to the largest supported job.
    always_comb begin
        clamped_rows = num_rows;
        if (num_rows > (AW+1)'(max_rows)) begin
            clamped_rows = (AW+1)'(max_rows);
        end
    end

    // A job is taken only from IDLE and never in the cycle done is showing.
    assign accept = (state == IDLE) && start && !done;

    // Job control: issue N reads, wait out the array latency, then pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            row_cnt   <= '0;
            job_rows  <= '0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy     <= 1'b1;
                        job_rows <= clamped_rows;
                        if (clamped_rows == '0) begin
                            state <= FIN;
                        end else begin
                            state   <= READ;
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                            row_cnt <= (AW+1)'(1);
                        end
                    end
                end
                READ: begin
                    if (row_cnt == job_rows) begin
                        rd_en     <= 1'b0;
                        rd_addr   <= '0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        rd_addr <= row_cnt[AW-1:0];
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(result_lat)) begin
                        state <= FIN;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data path: RAM data lands one cycle after rd_en and is registered into
    // prep_stream; anything that is not a fresh row is a zero flush row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld      <= 1'b0;
            prep_valid  <= 1'b0;
            prep_stream <= '0;
        end else begin
            rd_vld     <= rd_en;
            prep_valid <= rd_vld;
            if (rd_vld) begin
                prep_stream <= rd_data;
            end else begin
                prep_stream <= '0;
            end
        end
    end

    // Delay line that tracks each real row through the array to its result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_sr <= '0;
        end else begin
            valid_sr[0] <= prep_valid;
            for (int i = 1; i < result_lat; i++) begin
                valid_sr[i] <= valid_sr[i-1];
            end
        end
    end

    assign result_valid = valid_sr[result_lat-1];

`ifdef MULT_SEQ_PERF_EN
    // Job cycle count: the accept cycle plus every busy cycle, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= 32'd1;
        end else if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_matrix_sequencer.sv
// tb_mult_matrix_sequencer: directed, table-driven bench for the sequencer
// with a behavioural synchronous row RAM (size=3, data_size=4, max_rows=16).
module tb_mult_matrix_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  num_rows;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [11:0] rd_data;
    logic [11:0] prep_stream;
    logic        prep_valid;
    logic        result_valid;
`ifdef MULT_SEQ_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [16];

    typedef struct {
        logic        busy;
        logic        done;
        logic        rd_en;
        logic [3:0]  rd_addr;
        logic        prep_valid;
        logic [11:0] prep_stream;
        logic        result_valid;
    } vec_t;

    vec_t basic_tbl [12];

    mult_matrix_sequencer #(
        .data_size(4), .size(3), .max_rows(16), .result_lat(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_rows(num_rows),
        .busy(busy),
        .done(done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .prep_stream(prep_stream),
        .prep_valid(prep_valid),
`ifdef MULT_SEQ_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    // Synchronous row RAM: data appears the cycle after the read request.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic checkOutput(input string name, input int cyc,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Request a job; returns at the sampling point of cycle 1 after acceptance.
    task automatic applyStimulus(input logic [4:0] rows);
        @(negedge clk);
        start    = 1'b1;
        num_rows = rows;
        @(negedge clk);
        start    = 1'b0;
        num_rows = 5'd7;
    endtask

    task automatic checkAllZero(input string name, input int cyc);
        checkOutput({name, " busy"}, cyc, 32'(busy), 32'd0);
        checkOutput({name, " done"}, cyc, 32'(done), 32'd0);
        checkOutput({name, " rd_en"}, cyc, 32'(rd_en), 32'd0);
        checkOutput({name, " prep_valid"}, cyc, 32'(prep_valid), 32'd0);
        checkOutput({name, " prep_stream"}, cyc, 32'(prep_stream), 32'd0);
        checkOutput({name, " result_valid"}, cyc, 32'(result_valid), 32'd0);
    endtask

    // Basic 3-row job compared cycle by cycle against the hand-built table.
    task automatic runBasicTable(input string tag);
        applyStimulus(5'd3);
        for (int c = 0; c < 12; c++) begin
            checkOutput({tag, " busy"}, c + 1, 32'(busy), 32'(basic_tbl[c].busy));
            checkOutput({tag, " done"}, c + 1, 32'(done), 32'(basic_tbl[c].done));
            checkOutput({tag, " rd_en"}, c + 1, 32'(rd_en), 32'(basic_tbl[c].rd_en));
            if (basic_tbl[c].rd_en)
                checkOutput({tag, " rd_addr"}, c + 1, 32'(rd_addr), 32'(basic_tbl[c].rd_addr));
            checkOutput({tag, " prep_valid"}, c + 1, 32'(prep_valid), 32'(basic_tbl[c].prep_valid));
            checkOutput({tag, " prep_stream"}, c + 1, 32'(prep_stream), 32'(basic_tbl[c].prep_stream));
            checkOutput({tag, " result_valid"}, c + 1, 32'(result_valid), 32'(basic_tbl[c].result_valid));
`ifdef MULT_SEQ_PERF_EN
            if (c >= 10)
                checkOutput({tag, " perf_cycles"}, c + 1, perf_cycles, 32'd11);
`endif
            @(negedge clk);
        end
    endtask

    // Follow a job from the current sample until done, with a cycle budget.
    task automatic runToDone(input int budget, output int reads, output int results,
                             output int runs, output logic addr_ok, output logic found);
        logic prev_rv;
        reads = 0; results = 0; runs = 0; addr_ok = 1'b1; found = 1'b0; prev_rv = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            if (rd_en) begin
                if (rd_addr !== reads[3:0]) addr_ok = 1'b0;
                reads++;
            end
            if (result_valid) begin
                results++;
                if (!prev_rv) runs++;
            end
            prev_rv = result_valid;
            if (done) found = 1'b1;
            else @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int reads, results, runs;
        logic addr_ok, found;

        mem[0] = 12'h123;
        mem[1] = 12'h456;
        mem[2] = 12'h789;
        for (int i = 3; i < 16; i++) mem[i] = 12'hA00 + 12'(i);

        // cycle: busy done rd_en addr pv ps rv
        basic_tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 12'h000, 1'b0};
        basic_tbl[1]  = '{1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 12'h000, 1'b0};
        basic_tbl[2]  = '{1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 12'h123, 1'b0};
        basic_tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 12'h456, 1'b0};
        basic_tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 12'h789, 1'b0};
        basic_tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 12'h000, 1'b0};
        basic_tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 12'h000, 1'b0};
        basic_tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 12'h000, 1'b1};
        basic_tbl[8]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 12'h000, 1'b1};
        basic_tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 12'h000, 1'b1};
        basic_tbl[10] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 12'h000, 1'b0};
        basic_tbl[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 12'h000, 1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        num_rows = 5'd0;
        repeat (2) @(negedge clk);
        checkAllZero("reset", 0);
        reset = 1'b0;

        // Basic job.
        runBasicTable("basic");
`ifdef MULT_SEQ_PERF_EN
        repeat (3) @(negedge clk);
        checkOutput("perf hold", 15, perf_cycles, 32'd11);
`endif

        // Zero-row job: one busy cycle, then done, no activity.
        applyStimulus(5'd0);
        checkOutput("zero busy", 1, 32'(busy), 32'd1);
        checkOutput("zero done", 1, 32'(done), 32'd0);
        checkOutput("zero rd_en", 1, 32'(rd_en), 32'd0);
        @(negedge clk);
        checkOutput("zero busy", 2, 32'(busy), 32'd0);
        checkOutput("zero done", 2, 32'(done), 32'd1);
        for (int c = 3; c < 10; c++) begin
            @(negedge clk);
            checkAllZero("zero idle", c);
        end

        // Clamp: 20 rows requested, 16 serviced.
        applyStimulus(5'd20);
        runToDone(100, reads, results, runs, addr_ok, found);
        checkOutput("clamp done seen", 0, 32'(found), 32'd1);
        checkOutput("clamp reads", 0, 32'(reads), 32'd16);
        checkOutput("clamp addr seq", 0, 32'(addr_ok), 32'd1);
        checkOutput("clamp results", 0, 32'(results), 32'd16);
        checkOutput("clamp result runs", 0, 32'(runs), 32'd1);
        repeat (2) @(negedge clk);

        // Start pulses during DRAIN and on the done cycle are ignored.
        applyStimulus(5'd3);
        for (int c = 1; c <= 11; c++) begin
            checkOutput("busystart done", c, 32'(done), (c == 11) ? 32'd1 : 32'd0);
            start = (c == 6 || c == 11);
            num_rows = 5'd2;
            @(negedge clk);
        end
        checkOutput("busystart busy", 12, 32'(busy), 32'd0);
        checkOutput("busystart rd_en", 12, 32'(rd_en), 32'd0);
        // Start on the cycle after done launches a new job.
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        num_rows = 5'd9;
        checkOutput("restart busy", 13, 32'(busy), 32'd1);
        checkOutput("restart rd_en", 13, 32'(rd_en), 32'd1);
        runToDone(40, reads, results, runs, addr_ok, found);
        checkOutput("restart done seen", 0, 32'(found), 32'd1);
        checkOutput("restart reads", 0, 32'(reads), 32'd2);
        checkOutput("restart results", 0, 32'(results), 32'd2);
        repeat (2) @(negedge clk);

        // Reset mid-READ of a 4-row job.
        applyStimulus(5'd4);
        @(negedge clk);
        checkOutput("pre-reset rd_en", 2, 32'(rd_en), 32'd1);
        #2 reset = 1'b1;
        #1 checkAllZero("midreset", 2);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkAllZero("postreset", c);
        end
        runBasicTable("after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
